// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch sequencer: run/pause/lap state, 1 Hz prescaler off the
// 100 Hz tick, and an MM:SS BCD counter with a lap-freeze display register.
module stopwatch_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100,
    parameter int unsigned PS_W          = 7
) (
    input  logic        clk_100hz,
    input  logic        rst,
    input  logic        press_start,
    input  logic        press_lap,
    output logic [1:0]  state,
    output logic        running,
    output logic        lap_active,
    output logic [15:0] disp_bcd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

    state_t            state_q;
    state_t            state_d;
    logic              lap_capture_c;
    logic              live_clear_c;
    logic              counting_c;
    logic              sec_tick_c;
    logic [PS_W-1:0]   ps_q;
    bcd_time_t         live_q;
    bcd_time_t         lap_q;

    // Advance MM:SS by one second with per-digit carries; 59:59 wraps to 00:00.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_ones == 4'd9) begin
            n.sec_ones = 4'd0;
            if (t.sec_tens == 4'd5) begin
                n.sec_tens = 4'd0;
                if (t.min_ones == 4'd9) begin
                    n.min_ones = 4'd0;
                    n.min_tens = (t.min_tens == 4'd5) ? 4'd0 : t.min_tens + 4'd1;
                end else begin
                    n.min_ones = t.min_ones + 4'd1;
                end
            end else begin
                n.sec_tens = t.sec_tens + 4'd1;
            end
        end else begin
            n.sec_ones = t.sec_ones + 4'd1;
        end
        return n;
    endfunction

    // State register
    always_ff @(posedge clk_100hz) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and side-effect strobes; start beats lap when both pulse together
    always_comb begin
        state_d       = state_q;
        lap_capture_c = 1'b0;
        live_clear_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (press_start) begin
                    state_d = S_PAUSE;
                end else if (press_lap) begin
                    state_d       = S_LAP;
                    lap_capture_c = 1'b1;
                end
            end
            S_LAP: begin
                if (press_start) begin
                    state_d = S_PAUSE;
                end else if (press_lap) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (press_start) begin
                    state_d = S_RUN;
                end else if (press_lap) begin
                    state_d      = S_IDLE;
                    live_clear_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counting is gated by the registered state, so the RUN->PAUSE edge still counts
    assign counting_c = (state_q == S_RUN) || (state_q == S_LAP);
    assign sec_tick_c = counting_c && (ps_q == PS_LAST);

    always_ff @(posedge clk_100hz) begin
        if (rst) begin
            ps_q <= '0;
        end else if (live_clear_c) begin
            ps_q <= '0;
        end else if (counting_c) begin
            ps_q <= sec_tick_c ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk_100hz) begin
        if (rst) begin
            live_q <= '0;
        end else if (live_clear_c) begin
            live_q <= '0;
        end else if (sec_tick_c) begin
            live_q <= bcd_inc(live_q);
        end
    end

    // Lap register takes the pre-edge live count; only reset clears it
    always_ff @(posedge clk_100hz) begin
        if (rst) begin
            lap_q <= '0;
        end else if (lap_capture_c) begin
            lap_q <= live_q;
        end
    end

    assign state      = state_q;
    assign running    = counting_c;
    assign lap_active = (state_q == S_LAP);
    assign disp_bcd   = (state_q == S_LAP) ? lap_q : live_q;

endmodule
